// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock sequencer.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        ERROR,
        LOCKOUT
    } lock_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // The count holds at zero rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Keypad code entry controller: collects digits, checks the code, then drives
// a timed unlock window or, after repeated failures, a timed lockout.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                    NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0] PASSWORD     = 16'h1A2B,
    parameter int                    MAX_ATTEMPTS   = 3,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    LOCKOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_valid,
    input  logic [3:0]                        key_digit,
    input  logic                              enter,
    input  logic                              clear,
    input  logic                              lock_now,
    output logic                              unlocked,
    output logic                              wrong_code,
    output logic                              locked_out,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digits_entered
);

    localparam int CODE_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMR_W  = $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

    lock_state_t       state, state_next;
    logic [CODE_W-1:0] buffer, buffer_next;
    logic [CNT_W-1:0]  count_next;
    logic              overflow, overflow_next;
    logic [FAIL_W-1:0] fail_next, fail_inc;
    logic              timer_load, timer_en, timer_done;
    logic [TMR_W-1:0]  timer_val;

    lock_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    always_comb begin
        state_next    = state;
        buffer_next   = buffer;
        count_next    = digits_entered;
        overflow_next = overflow;
        fail_next     = fail_count;
        fail_inc      = fail_count + FAIL_W'(1);
        timer_load    = 1'b0;
        timer_val     = '0;
        timer_en      = 1'b0;

        case (state)
            IDLE, ENTRY: begin
                if (clear) begin
                    buffer_next   = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    if (key_valid) begin
                        if (digits_entered == CNT_W'(NUM_DIGITS)) begin
                            overflow_next = 1'b1;
                        end else begin
                            buffer_next = (buffer << 4) | CODE_W'(key_digit);
                            count_next  = digits_entered + CNT_W'(1);
                        end
                        state_next = ENTRY;
                    end
                    if (enter && (state == ENTRY || key_valid)) begin
                        state_next = CHECK;
                    end
                end
            end

            // Timer is loaded with N-1 so the window lasts N cycles ending on done.
            CHECK: begin
                buffer_next   = '0;
                count_next    = '0;
                overflow_next = 1'b0;
                if (digits_entered == CNT_W'(NUM_DIGITS) && !overflow && buffer == PASSWORD) begin
                    fail_next  = '0;
                    state_next = OPEN;
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(UNLOCK_CYCLES - 1);
                end else begin
                    fail_next = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_ATTEMPTS)) begin
                        state_next = LOCKOUT;
                        timer_load = 1'b1;
                        timer_val  = TMR_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_next = ERROR;
                    end
                end
            end

            ERROR: begin
                state_next = IDLE;
            end

            OPEN: begin
                timer_en = 1'b1;
                if (lock_now || timer_done) begin
                    state_next = IDLE;
                end
            end

            LOCKOUT: begin
                timer_en = 1'b1;
                if (timer_done) begin
                    fail_next  = '0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            buffer         <= '0;
            digits_entered <= '0;
            overflow       <= 1'b0;
            fail_count     <= '0;
            unlocked       <= 1'b0;
            wrong_code     <= 1'b0;
            locked_out     <= 1'b0;
        end else begin
            state          <= state_next;
            buffer         <= buffer_next;
            digits_entered <= count_next;
            overflow       <= overflow_next;
            fail_count     <= fail_next;
            unlocked       <= (state_next == OPEN);
            wrong_code     <= (state_next == ERROR);
            locked_out     <= (state_next == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with short timer windows.
module tb_lock_sequencer;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       enter;
    logic       clear;
    logic       lock_now;
    logic       unlocked;
    logic       wrong_code;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] digits_entered;

    int checks = 0;
    int errors = 0;
    int cnt;
    int pulses;

    lock_sequencer #(
        .NUM_DIGITS     (4),
        .PASSWORD       (16'h1A2B),
        .MAX_ATTEMPTS   (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_digit      (key_digit),
        .enter          (enter),
        .clear          (clear),
        .lock_now       (lock_now),
        .unlocked       (unlocked),
        .wrong_code     (wrong_code),
        .locked_out     (locked_out),
        .fail_count     (fail_count),
        .digits_entered (digits_entered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic kv, input logic [3:0] d, input logic ent,
                                 input logic clr, input logic lk);
        key_valid = kv;
        key_digit = d;
        enter     = ent;
        clear     = clr;
        lock_now  = lk;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_digit = 4'h0;
        enter     = 1'b0;
        clear     = 1'b0;
        lock_now  = 1'b0;
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        key_valid = 1'b0;
        key_digit = 4'h0;
        enter     = 1'b0;
        clear     = 1'b0;
        lock_now  = 1'b0;
        reset     = 1'b1;

        @(posedge clk);
        #1;
        checkOutput("rst_unlocked", 32'(unlocked), 32'd0);
        checkOutput("rst_wrong", 32'(wrong_code), 32'd0);
        checkOutput("rst_locked", 32'(locked_out), 32'd0);
        checkOutput("rst_fail", 32'(fail_count), 32'd0);
        checkOutput("rst_digits", 32'(digits_entered), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Correct code unlocks for exactly 8 cycles.
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        checkOutput("digits_one", 32'(digits_entered), 32'd1);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        checkOutput("digits_four", 32'(digits_entered), 32'd4);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("open_latency_low", 32'(unlocked), 32'd0);
        idle_cycle();
        checkOutput("open_first", 32'(unlocked), 32'd1);
        checkOutput("open_fail", 32'(fail_count), 32'd0);
        checkOutput("open_digits_cleared", 32'(digits_entered), 32'd0);
        cnt = 1;
        for (int i = 0; i < 19; i++) begin
            idle_cycle();
            if (unlocked) cnt++;
        end
        checkOutput("open_length", 32'(cnt), 32'd8);

        // Single wrong code: one wrong_code pulse.
        enter_code(16'h1A2C);
        checkOutput("err_latency_low", 32'(wrong_code), 32'd0);
        idle_cycle();
        checkOutput("err_pulse", 32'(wrong_code), 32'd1);
        checkOutput("err_fail1", 32'(fail_count), 32'd1);
        idle_cycle();
        checkOutput("err_pulse_end", 32'(wrong_code), 32'd0);
        checkOutput("err_no_unlock", 32'(unlocked), 32'd0);

        // Second and third failures: pulse, then lockout with no pulse.
        pulses = 0;
        enter_code(16'h1111);
        idle_cycle();
        if (wrong_code) pulses++;
        idle_cycle();
        if (wrong_code) pulses++;
        checkOutput("second_fail_pulses", 32'(pulses), 32'd1);
        checkOutput("second_fail_count", 32'(fail_count), 32'd2);
        enter_code(16'h2222);
        idle_cycle();
        checkOutput("lock_first", 32'(locked_out), 32'd1);
        checkOutput("lock_no_wrong", 32'(wrong_code), 32'd0);
        checkOutput("lock_fail3", 32'(fail_count), 32'd3);
        cnt = 1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
            if (locked_out) cnt++;
        end
        checkOutput("lock_digits_ignored", 32'(digits_entered), 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            if (locked_out) cnt++;
        end
        checkOutput("lock_length", 32'(cnt), 32'd16);
        checkOutput("lock_fail_reset", 32'(fail_count), 32'd0);
        enter_code(16'h1A2B);
        idle_cycle();
        checkOutput("post_lock_unlock", 32'(unlocked), 32'd1);
        repeat (10) idle_cycle();
        checkOutput("post_lock_closed", 32'(unlocked), 32'd0);

        // Overflow and short entries both fail.
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_digits_sat", 32'(digits_entered), 32'd4);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        checkOutput("ovf_wrong", 32'(wrong_code), 32'd1);
        checkOutput("ovf_fail", 32'(fail_count), 32'd1);
        idle_cycle();
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        checkOutput("short_wrong", 32'(wrong_code), 32'd1);
        checkOutput("short_fail", 32'(fail_count), 32'd2);
        idle_cycle();

        // Clear wins over a simultaneous digit; then lock_now ends the window.
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_digits", 32'(digits_entered), 32'd0);
        enter_code(16'h1A2B);
        idle_cycle();
        checkOutput("ln_c1", 32'(unlocked), 32'd1);
        checkOutput("ln_fail_zero", 32'(fail_count), 32'd0);
        idle_cycle();
        idle_cycle();
        checkOutput("ln_c3", 32'(unlocked), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("ln_dropped", 32'(unlocked), 32'd0);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        checkOutput("ln_back_idle", 32'(digits_entered), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a lockout.
        enter_code(16'h0000);
        idle_cycle();
        idle_cycle();
        enter_code(16'h0001);
        idle_cycle();
        idle_cycle();
        enter_code(16'h0002);
        idle_cycle();
        checkOutput("rlock_locked", 32'(locked_out), 32'd1);
        repeat (3) idle_cycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rlock_async_locked", 32'(locked_out), 32'd0);
        checkOutput("rlock_async_fail", 32'(fail_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle();
        checkOutput("rlock_stays_idle", 32'(locked_out), 32'd0);
        enter_code(16'h1A2B);
        idle_cycle();
        checkOutput("rlock_unlock", 32'(unlocked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
